// File: rtl/pwm_dds_pkg.sv
// Shared widths, reset constants and the sine lookup for the DDS/PWM tone generator.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pwm_dds_pkg;

  localparam int PHASE_W   = 32;
  localparam int TOP_W     = 8;
  localparam int CMP_W     = 9;
  localparam int IDX_W     = 8;
  localparam int CMP_SHIFT = 3;
  localparam int SAW_SHIFT = 2;

  localparam logic [TOP_W-1:0] TOP_RESET_DEF = 8'd63;

  // Quarter-wave amplitude round(255*sin(pi*k/128)) for k = 0..64.
  function automatic logic [7:0] quarter_sin(input logic [6:0] k);
    logic [7:0] v;
    case (k)
      7'd0:  v = 8'd0;   7'd1:  v = 8'd6;   7'd2:  v = 8'd13;  7'd3:  v = 8'd19;
      7'd4:  v = 8'd25;  7'd5:  v = 8'd31;  7'd6:  v = 8'd37;  7'd7:  v = 8'd44;
      7'd8:  v = 8'd50;  7'd9:  v = 8'd56;  7'd10: v = 8'd62;  7'd11: v = 8'd68;
      7'd12: v = 8'd74;  7'd13: v = 8'd80;  7'd14: v = 8'd86;  7'd15: v = 8'd92;
      7'd16: v = 8'd98;  7'd17: v = 8'd103; 7'd18: v = 8'd109; 7'd19: v = 8'd115;
      7'd20: v = 8'd120; 7'd21: v = 8'd126; 7'd22: v = 8'd131; 7'd23: v = 8'd136;
      7'd24: v = 8'd142; 7'd25: v = 8'd147; 7'd26: v = 8'd152; 7'd27: v = 8'd157;
      7'd28: v = 8'd162; 7'd29: v = 8'd167; 7'd30: v = 8'd171; 7'd31: v = 8'd176;
      7'd32: v = 8'd180; 7'd33: v = 8'd185; 7'd34: v = 8'd189; 7'd35: v = 8'd193;
      7'd36: v = 8'd197; 7'd37: v = 8'd201; 7'd38: v = 8'd205; 7'd39: v = 8'd208;
      7'd40: v = 8'd212; 7'd41: v = 8'd215; 7'd42: v = 8'd219; 7'd43: v = 8'd222;
      7'd44: v = 8'd225; 7'd45: v = 8'd228; 7'd46: v = 8'd231; 7'd47: v = 8'd233;
      7'd48: v = 8'd236; 7'd49: v = 8'd238; 7'd50: v = 8'd240; 7'd51: v = 8'd242;
      7'd52: v = 8'd244; 7'd53: v = 8'd246; 7'd54: v = 8'd247; 7'd55: v = 8'd249;
      7'd56: v = 8'd250; 7'd57: v = 8'd251; 7'd58: v = 8'd252; 7'd59: v = 8'd253;
      7'd60: v = 8'd254; 7'd61: v = 8'd254; 7'd62: v = 8'd255; 7'd63: v = 8'd255;
      default: v = 8'd255;
    endcase
    return v;
  endfunction

  // Full-period sample round(256+255*sin(2*pi*idx/256)) built from the quarter wave
  // by mirroring in the 2nd/4th quadrants and negating in the lower half.
  function automatic logic [CMP_W-1:0] sine_lookup(input logic [IDX_W-1:0] idx);
    logic [6:0] k;
    logic [7:0] a;
    if (idx[IDX_W-2]) k = 7'd64 - {1'b0, idx[5:0]};
    else              k = {1'b0, idx[5:0]};
    a = quarter_sin(k);
    return idx[IDX_W-1] ? (9'd256 - {1'b0, a}) : (9'd256 + {1'b0, a});
  endfunction

endpackage

// File: rtl/pwm_dds_sine_rom.sv
// 256x9 sine table indexed by the top phase byte.
// Latency: 1 clock (registered output, cleared by reset).
// Backpressure: none; a new index is looked up every clock.
module pwm_dds_sine_rom
  import pwm_dds_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_idx,
  output logic [CMP_W-1:0] o_dat
);

  logic [CMP_W-1:0] dat_d;
  logic [CMP_W-1:0] dat_q;

  // Table lookup for the current index.
  always_comb begin
    dat_d = sine_lookup(i_idx);
  end

  // Output register gives the synchronous-ROM read behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) dat_q <= '0;
    else          dat_q <= dat_d;
  end

  assign o_dat = dat_q;

endmodule

// File: rtl/pwm_dds_core.sv
// DDS phase accumulator driving a 6-bit-level PWM audio output; PWM_DDS_SINE_EN selects sine ROM, else sawtooth.
// Latency: delta/top take effect next edge / next PWM cycle end; phase->compare 1 clock.
// Backpressure: none; valid strobes are captured unconditionally, no ready.
module pwm_dds_core
  import pwm_dds_pkg::*;
#(
  parameter logic [TOP_W-1:0] TOP_RESET = TOP_RESET_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [TOP_W-1:0]   i_top,
  input  logic               i_top_valid,
  input  logic [PHASE_W-1:0] i_phase_delta,
  input  logic               i_phase_delta_valid,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_pwm,
  output logic               o_pwm_n,
  output logic               o_cycle_end
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] delta_q, delta_d;
  logic [TOP_W-1:0]   cnt_q, cnt_d;
  logic [TOP_W-1:0]   top_act_q, top_act_d;
  logic [TOP_W-1:0]   top_pend_q, top_pend_d;
  logic [CMP_W-1:0]   cmp_act_q, cmp_act_d;
  logic [CMP_W-1:0]   cmp_cur;
  logic [IDX_W-1:0]   idx;
  logic               cycle_end;

  assign idx = phase_q[PHASE_W-1 -: IDX_W];

`ifdef PWM_DDS_SINE_EN
  logic [CMP_W-1:0] rom_dat;

  pwm_dds_sine_rom u_sine_rom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_idx   (idx),
    .o_dat   (rom_dat)
  );

  assign cmp_cur = rom_dat >> CMP_SHIFT;
`else
  logic [CMP_W-1:0] cmp_q, cmp_d;

  // Sawtooth level straight from the phase index.
  always_comb begin
    cmp_d = {1'b0, idx} >> SAW_SHIFT;
  end

  // Register the level so both waveform builds share the same latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cmp_q <= '0;
    else          cmp_q <= cmp_d;
  end

  assign cmp_cur = cmp_q;
`endif

  assign cycle_end = (cnt_q == top_act_q);

  // Next-state: accumulator, parameter capture and period-aligned shadow updates.
  always_comb begin
    phase_d    = phase_q + delta_q;
    delta_d    = i_phase_delta_valid ? i_phase_delta : delta_q;
    // A coincident top strobe lands in pending; the old pending value goes live now.
    top_pend_d = i_top_valid ? i_top : top_pend_q;
    cnt_d      = cnt_q + 8'd1;
    top_act_d  = top_act_q;
    cmp_act_d  = cmp_act_q;
    if (cycle_end) begin
      cnt_d     = '0;
      top_act_d = top_pend_q;
      cmp_act_d = cmp_cur;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q    <= '0;
      delta_q    <= '0;
      cnt_q      <= '0;
      top_act_q  <= TOP_RESET;
      top_pend_q <= TOP_RESET;
      cmp_act_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      delta_q    <= delta_d;
      cnt_q      <= cnt_d;
      top_act_q  <= top_act_d;
      top_pend_q <= top_pend_d;
      cmp_act_q  <= cmp_act_d;
    end
  end

  assign o_phase     = phase_q;
  assign o_pwm       = ({1'b0, cnt_q} < cmp_act_q);
  assign o_pwm_n     = ~o_pwm;
  assign o_cycle_end = cycle_end;

endmodule

// File: tb/tb_pwm_dds_core.sv
`timescale 1ns/1ps
module tb_pwm_dds_core;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_top = '0;
  logic        i_top_valid = 1'b0;
  logic [31:0] i_phase_delta = '0;
  logic        i_phase_delta_valid = 1'b0;
  logic [31:0] o_phase;
  logic        o_pwm;
  logic        o_pwm_n;
  logic        o_cycle_end;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PWM_DDS_SINE_EN
  localparam int HI_PH00 = 32;  // ROM[0]=256   -> 32
  localparam int HI_PH40 = 63;  // ROM[64]=511  -> 63
`else
  localparam int HI_PH00 = 0;   // idx 0  -> 0
  localparam int HI_PH40 = 16;  // idx 64 -> 16
`endif

  always #5 i_clk = ~i_clk;

  pwm_dds_core dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_top               (i_top),
    .i_top_valid         (i_top_valid),
    .i_phase_delta       (i_phase_delta),
    .i_phase_delta_valid (i_phase_delta_valid),
    .o_phase             (o_phase),
    .o_pwm               (o_pwm),
    .o_pwm_n             (o_pwm_n),
    .o_cycle_end         (o_cycle_end)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_top_valid = 1'b0;
    i_phase_delta_valid = 1'b0;
    i_top = '0;
    i_phase_delta = '0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  // Park the accumulator at phase p with delta 0 (2 clocks).
  task automatic set_phase(input logic [31:0] p);
    i_phase_delta = p;
    i_phase_delta_valid = 1'b1;
    tick();
    i_phase_delta = '0;
    tick();
    i_phase_delta_valid = 1'b0;
  endtask

  task automatic wait_ce(output int n);
    n = 0;
    while (o_cycle_end !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  // From a cycle_end clock, run one full period; strobes last only the first edge.
  task automatic measure(output int len, output int hi);
    len = 0;
    hi = 0;
    do begin
      tick();
      i_top_valid = 1'b0;
      i_phase_delta_valid = 1'b0;
      len++;
      if (o_pwm === 1'b1) hi++;
    end while (o_cycle_end !== 1'b1 && len < 300);
  endtask

  initial begin
    int n, len, hi;

    // Reset state
    i_rst_n = 1'b0;
    tick();
    tick();
    chk("rst_phase", o_phase, 32'd0);
    chk("rst_pwm", {31'd0, o_pwm}, 32'd0);
    chk("rst_pwm_n", {31'd0, o_pwm_n}, 32'd1);
    chk("rst_ce", {31'd0, o_cycle_end}, 32'd0);
    i_rst_n = 1'b1;

    // Delta 440 Hz: loaded delta accumulates from the following edge
    i_phase_delta = 32'd75591;
    i_phase_delta_valid = 1'b1;
    tick();
    i_phase_delta_valid = 1'b0;
    chk("delta_load", o_phase, 32'd0);
    tick();
    chk("delta_1", o_phase, 32'd75591);
    for (int i = 0; i < 9; i++) tick();
    chk("delta_10", o_phase, 32'd755910);

    // Half-scale delta: phase alternates with silent wrap
    do_reset();
    i_phase_delta = 32'h8000_0000;
    i_phase_delta_valid = 1'b1;
    tick();
    i_phase_delta_valid = 1'b0;
    chk("half_load", o_phase, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("half_alt", o_phase, (i % 2 == 0) ? 32'h8000_0000 : 32'h0);
    end

    // Phase 0, default top 63: period 64, duty from index 0
    do_reset();
    wait_ce(n);
    chk("ph0_first_ce", n, 32'd63);
    measure(len, hi);
    chk("ph0_len", len, 32'd64);
    chk("ph0_hi", hi, HI_PH00);
    measure(len, hi);
    chk("ph0_len2", len, 32'd64);
    chk("ph0_hi2", hi, HI_PH00);

    // Compare 32 (index 128), top 15 strobed mid-period
    do_reset();
    set_phase(32'h8000_0000);
    i_top = 8'd15;
    i_top_valid = 1'b1;
    tick();
    i_top_valid = 1'b0;
    wait_ce(n);
    chk("t15_first_ce", n, 32'd60);
    measure(len, hi);
    chk("t15_len", len, 32'd16);
    chk("t15_hi", hi, 32'd16);
    chk("t15_pwm_n", {31'd0, o_pwm_n}, 32'd0);
    measure(len, hi);
    chk("t15_len2", len, 32'd16);
    chk("t15_hi2", hi, 32'd16);

    // Half duty, then top strobes coincident with cycle_end
    do_reset();
    set_phase(32'h8000_0000);
    wait_ce(n);
    chk("duty_first_ce", n, 32'd61);
    measure(len, hi);
    chk("duty_len", len, 32'd64);
    chk("duty_hi", hi, 32'd32);
    i_top = 8'd3;
    i_top_valid = 1'b1;
    measure(len, hi);
    chk("coin_keep_len", len, 32'd64);
    chk("coin_keep_hi", hi, 32'd32);
    measure(len, hi);
    chk("coin_new_len", len, 32'd4);
    chk("coin_new_hi", hi, 32'd4);
    i_top = 8'd0;
    i_top_valid = 1'b1;
    measure(len, hi);
    chk("top0_keep_len", len, 32'd4);
    measure(len, hi);
    chk("top0_len", len, 32'd1);
    chk("top0_hi", hi, 32'd1);
    measure(len, hi);
    chk("top0_len2", len, 32'd1);
    chk("top0_hi2", hi, 32'd1);

    // Mid-run async reset: outputs clear without a clock edge
    chk("pre_rst_pwm", {31'd0, o_pwm}, 32'd1);
    chk("pre_rst_phase", o_phase, 32'h8000_0000);
    i_rst_n = 1'b0;
    #2;
    chk("async_phase", o_phase, 32'd0);
    chk("async_pwm", {31'd0, o_pwm}, 32'd0);
    chk("async_pwm_n", {31'd0, o_pwm_n}, 32'd1);

    // Quarter phase: waveform level at index 64
    do_reset();
    set_phase(32'h4000_0000);
    wait_ce(n);
    measure(len, hi);
    chk("ph40_len", len, 32'd64);
    chk("ph40_hi", hi, HI_PH40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
